// File: rtl/game_pkg.sv
// Shared constants for the Flappy game sequencer: FSM state encodings,
// BCD score limits and the BCD increment helper.
package game_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_INIT       = 3'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_FRAME = 3'd1;
    localparam logic [STATE_W-1:0] ST_PHYS       = 3'd2;
    localparam logic [STATE_W-1:0] ST_PIPE       = 3'd3;
    localparam logic [STATE_W-1:0] ST_CHECK      = 3'd4;
    localparam logic [STATE_W-1:0] ST_LOSE       = 3'd5;

    localparam int          DIGIT_W    = 4;
    localparam int          NUM_DIGITS = 4;
    localparam logic [15:0] BCD_MAX    = 16'h9999;

    // Ripple a +1 through the BCD digits, wrapping a 9 to 0 and carrying on.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (result[i*DIGIT_W +: DIGIT_W] == 4'd9) begin
                    result[i*DIGIT_W +: DIGIT_W] = 4'd0;
                end else begin
                    result[i*DIGIT_W +: DIGIT_W] = result[i*DIGIT_W +: DIGIT_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Four-digit BCD score register with synchronous clear and an increment that
// saturates at 9999.
module bcd_score_counter
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] score
);

    logic [15:0] score_q;
    logic [15:0] score_d;

    always_comb begin
        score_d = score_q;
        if (clr) begin
            score_d = '0;
        end else if (inc && (score_q != BCD_MAX)) begin
            score_d = bcd_inc(score_q);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;

endmodule

// File: rtl/game_sequencer.sv
// Flappy game controller: turns VGA frame pulses into physics/pipe/check steps,
// owns game state, jump latch and score. Optional Pause input: GAME_SEQ_PAUSE_EN.
module game_sequencer
    import game_pkg::*;
#(
    parameter int FRAME_DIV   = 2,
    parameter int CHK_TIMEOUT = 64
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        frame_sync,
    input  logic        Start,
    input  logic        Ack,
    input  logic        Jump,
    input  logic        pipe_passed,
    input  logic        chk_done,
    input  logic        chk_hit,
`ifdef GAME_SEQ_PAUSE_EN
    input  logic        Pause,
`endif
    output logic        phys_step,
    output logic        jump_out,
    output logic        pipe_step,
    output logic        chk_req,
    output logic        game_clr,
    output logic [15:0] Score,
    output logic        q_Initial,
    output logic        q_Run,
    output logic        q_Lose,
    output logic        overrun,
    output logic        timeout_err
);

    localparam int                CHK_W      = (CHK_TIMEOUT > 1) ? $clog2(CHK_TIMEOUT) : 1;
    localparam logic [CHK_W-1:0]  CHK_LAST   = CHK_W'(CHK_TIMEOUT - 1);
    localparam logic [3:0]        FRAME_LAST = 4'(FRAME_DIV - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [3:0]         frame_cnt_q, frame_cnt_d;
    logic [CHK_W-1:0]   chk_cnt_q, chk_cnt_d;
    logic               jump_lat_q, jump_lat_d;
    logic               overrun_q, overrun_d;
    logic               timeout_q, timeout_d;
    logic               game_clr_q, game_clr_d;
    logic               phys_step_q, phys_step_d;
    logic               jump_out_q, jump_out_d;
    logic               pipe_step_q, pipe_step_d;
    logic               chk_req_q, chk_req_d;

    logic in_run;
    logic in_step;
    logic entering_phys;
    logic frame_hold;

    assign in_run  = (state_q == ST_WAIT_FRAME) || in_step;
    assign in_step = (state_q == ST_PHYS) || (state_q == ST_PIPE) || (state_q == ST_CHECK);

`ifdef GAME_SEQ_PAUSE_EN
    logic paused_q, paused_d;

    always_comb begin
        paused_d = paused_q;
        if (game_clr_d || ((state_q == ST_LOSE) && Ack)) begin
            paused_d = 1'b0;
        end else if (Pause && in_run) begin
            paused_d = !paused_q;
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            paused_q <= 1'b0;
        end else begin
            paused_q <= paused_d;
        end
    end

    // Only the frame divider sees the pause; a step already in flight finishes.
    assign frame_hold = paused_q;
`else
    assign frame_hold = 1'b0;
`endif

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        chk_cnt_d   = '0;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;
        game_clr_d  = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (Start) begin
                    state_d     = ST_WAIT_FRAME;
                    game_clr_d  = 1'b1;
                    frame_cnt_d = '0;
                    overrun_d   = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            ST_WAIT_FRAME: begin
                if (frame_sync && !frame_hold) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = '0;
                        state_d     = ST_PHYS;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 4'd1;
                    end
                end
            end
            ST_PHYS:  state_d = ST_PIPE;
            ST_PIPE:  state_d = ST_CHECK;
            ST_CHECK: begin
                if (chk_done) begin
                    state_d = chk_hit ? ST_LOSE : ST_WAIT_FRAME;
                end else if (chk_cnt_q == CHK_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_LOSE;
                end else begin
                    chk_cnt_d = chk_cnt_q + 1'b1;
                end
            end
            ST_LOSE: begin
                if (Ack) begin
                    state_d = ST_INIT;
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (frame_sync && in_step) begin
            overrun_d = 1'b1;
        end
    end

    // A Jump sampled on the edge into PHYS is consumed by that step; one during PHYS waits.
    assign entering_phys = (state_q == ST_WAIT_FRAME) && (state_d == ST_PHYS);

    always_comb begin
        jump_lat_d = jump_lat_q;
        if (game_clr_d || entering_phys) begin
            jump_lat_d = 1'b0;
        end else if (Jump && in_run) begin
            jump_lat_d = 1'b1;
        end
    end

    always_comb begin
        phys_step_d = (state_d == ST_PHYS);
        pipe_step_d = (state_d == ST_PIPE);
        chk_req_d   = (state_d == ST_CHECK);
        jump_out_d  = entering_phys && (jump_lat_q || (Jump && in_run));
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            frame_cnt_q <= '0;
            chk_cnt_q   <= '0;
            jump_lat_q  <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            game_clr_q  <= 1'b0;
            phys_step_q <= 1'b0;
            jump_out_q  <= 1'b0;
            pipe_step_q <= 1'b0;
            chk_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            chk_cnt_q   <= chk_cnt_d;
            jump_lat_q  <= jump_lat_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            game_clr_q  <= game_clr_d;
            phys_step_q <= phys_step_d;
            jump_out_q  <= jump_out_d;
            pipe_step_q <= pipe_step_d;
            chk_req_q   <= chk_req_d;
        end
    end

    bcd_score_counter u_score (
        .clk   (Clk),
        .rst_n (reset_n),
        .clr   (game_clr_d),
        .inc   (pipe_passed && in_run),
        .score (Score)
    );

    assign phys_step   = phys_step_q;
    assign jump_out    = jump_out_q;
    assign pipe_step   = pipe_step_q;
    assign chk_req     = chk_req_q;
    assign game_clr    = game_clr_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;
    assign q_Initial   = (state_q == ST_INIT);
    assign q_Run       = in_run;
    assign q_Lose      = (state_q == ST_LOSE);

endmodule
